// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver
//
// Receives PS/2 keyboard frames and turns them into one-cycle key events.
// A frame is a start bit (0), 8 data bits sent LSB first, an odd-parity bit and
// a stop bit (1). Data is sampled on each falling edge of PS2_CLK. F0 (break)
// and E0 (extended) prefix bytes are absorbed into pending flags, and the next
// ordinary byte is reported as one event carrying those flags.
//
// Parameters
//   SYNC_STAGES     flops in each PS2_CLK / PS2_DAT synchroniser (>= 2)
//   TIMEOUT_CYCLES  clk cycles without a PS2_CLK falling edge before a
//                   partial frame is abandoned
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, a parity mismatch makes the frame bad.
//                        When undefined, parity is sampled but ignored.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   PS2_CLK    in   raw keyboard clock (asynchronous)
//   PS2_DAT    in   raw keyboard data (asynchronous)
//   valid      out  one-cycle pulse: new event on makeBreak/outCode/extended
//   makeBreak  out  1 = make (press), 0 = break (release)
//   outCode    out  scan code of the event, held until the next valid
//   extended   out  event was prefixed by E0
//   frame_err  out  one-cycle pulse: bad start, stop or parity bit
//
// Frame FSM
//   state  | meaning
//   IDLE   | waiting for a start bit; timeout counter held at 0
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | sampling the parity bit
//   STOP   | sampling the stop bit; frame is judged on this edge

module ps2_scan_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       valid,
    output logic       makeBreak,
    output logic [7:0] outCode,
    output logic       extended,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s;
    logic                   ps2_dat_s;
    logic                   fall;

    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_cnt;
    logic          break_pend;
    logic          ext_pend;

    logic frame_done;
    logic start_err;
    logic tmo_hit;
    logic parity_ok;
    logic frame_good;
    logic good_byte;
    logic bad_frame;
    logic valid_d;

    // Synchronisers reset to 1 (the PS/2 idle level) so that releasing reset
    // never manufactures a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
            clk_prev <= ps2_clk_s;
        end
    end

    assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~ps2_clk_s;

    // An edge in the same cycle as the terminal count wins over the timeout.
    assign tmo_hit = (state_q != IDLE) && !fall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        start_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!ps2_dat_s) state_d = DATA;
                    else            start_err = 1'b1;
                end
            end
            DATA: begin
                if (fall && bit_cnt == 3'd7) state_d = PARITY;
            end
            PARITY: begin
                if (fall) state_d = STOP;
            end
            STOP: begin
                if (fall) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    assign parity_ok = ^{shift_q, par_q};

`ifdef PS2_PARITY_CHECK_EN
    assign frame_good = ps2_dat_s & parity_ok;
`else
    // Parity is captured but deliberately not acted on in this build.
    logic parity_unused;
    assign parity_unused = parity_ok;
    assign frame_good    = ps2_dat_s;
`endif

    assign good_byte = frame_done & frame_good;
    assign bad_frame = start_err | (frame_done & ~frame_good);
    assign valid_d   = good_byte && (shift_q != CODE_BREAK) && (shift_q != CODE_EXT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
        end else if (fall) begin
            case (state_q)
                IDLE:    bit_cnt <= 3'd0;
                DATA: begin
                    shift_q <= {ps2_dat_s, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                PARITY:  par_q <= ps2_dat_s;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state_q == IDLE || state_d == IDLE || fall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A timeout leaves the pend flags alone: only judged frames touch them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
        end else if (bad_frame) begin
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
        end else if (good_byte) begin
            if (shift_q == CODE_BREAK) begin
                break_pend <= 1'b1;
            end else if (shift_q == CODE_EXT) begin
                ext_pend <= 1'b1;
            end else begin
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            makeBreak <= 1'b0;
            outCode   <= 8'h00;
            extended  <= 1'b0;
        end else begin
            valid     <= valid_d;
            frame_err <= bad_frame;
            if (valid_d) begin
                makeBreak <= ~break_pend;
                outCode   <= shift_q;
                extended  <= ext_pend;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: directed test-plan frames followed by random
// frames, checked against a frame-level reference model of key events.
module tb_ps2_scan_receiver;

    localparam int SYNC = 2;
    localparam int TMO  = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       extended;
    logic       frame_err;

    ps2_scan_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .valid     (valid),
        .makeBreak (makeBreak),
        .outCode   (outCode),
        .extended  (extended),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observation side
    int         cyc = 0;
    int         edge_cyc = 0;
    int         last_lat = 0;
    bit         lat_seen = 0;
    int         obs_err = 0;
    int         hold_viol = 0;
    int         both_viol = 0;
    logic [9:0] obs_q[$];
    logic [9:0] prev_out = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            if (valid) begin
                obs_q.push_back({makeBreak, extended, outCode});
                last_lat = cyc - edge_cyc;
                lat_seen = 1;
            end
            if (frame_err) begin
                obs_err++;
                last_lat = cyc - edge_cyc;
                lat_seen = 1;
            end
            if (valid && frame_err) both_viol++;
            if (!valid && ({makeBreak, extended, outCode} != prev_out)) hold_viol++;
        end
        prev_out = {makeBreak, extended, outCode};
    end

    // Reference model: one call per judged frame.
    bit         bp = 0;
    bit         ep = 0;
    int         exp_err = 0;
    logic [9:0] exp_q[$];

    task automatic model_frame(input logic start, input logic [7:0] b,
                               input logic par, input logic stp);
        bit good;
        if (start) begin
            good = 0;
        end else begin
            good = stp;
`ifdef PS2_PARITY_CHECK_EN
            if (($countones(b) + par) % 2 == 0) good = 0;
`endif
        end
        if (!good) begin
            exp_err++;
            bp = 0;
            ep = 0;
        end else if (b == 8'hF0) begin
            bp = 1;
        end else if (b == 8'hE0) begin
            ep = 1;
        end else begin
            exp_q.push_back({~bp, ep, b});
            bp = 0;
            ep = 0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            PS2_DAT = bits[i];
            repeat (8) @(negedge clk);
            PS2_CLK  = 1'b0;
            edge_cyc = cyc;
            repeat (16) @(negedge clk);
            PS2_CLK = 1'b1;
            repeat (8) @(negedge clk);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic compare(input string tag);
        check({tag, ".n_evt"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, ".evt"}, {22'd0, obs_q.pop_front()}, {22'd0, exp_q.pop_front()});
        obs_q.delete();
        exp_q.delete();
        check({tag, ".n_err"}, obs_err, exp_err);
        obs_err = 0;
        exp_err = 0;
        if (lat_seen) check({tag, ".lat_ok"}, (last_lat >= SYNC + 1 && last_lat <= SYNC + 3), 1);
        lat_seen = 0;
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    task automatic frame(input string tag, input logic [7:0] b, input logic par, input logic stp);
        send_bits({stp, par, b, 1'b0}, 11);
        model_frame(1'b0, b, par, stp);
        repeat (4) @(negedge clk);
        compare(tag);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stp;
        int         r;

        reset   = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_out", {valid, makeBreak, extended, frame_err, outCode}, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        frame("make_1d", 8'h1D, 1'b1, 1'b1);

        frame("brk_f0", 8'hF0, good_par(8'hF0), 1'b1);
        frame("brk_1d", 8'h1D, 1'b1, 1'b1);

        frame("ext_e0", 8'hE0, good_par(8'hE0), 1'b1);
        frame("ext_f0", 8'hF0, good_par(8'hF0), 1'b1);
        frame("ext_74", 8'h74, good_par(8'h74), 1'b1);

        frame("badpar_1c", 8'h1C, 1'b1, 1'b1);

        // Start plus 4 data bits, then a stall past the timeout.
        send_bits({1'b1, 1'b0, 8'h23, 1'b0}, 5);
        repeat (TMO + 10) @(negedge clk);
        compare("stall");
        frame("tmo_23", 8'h23, good_par(8'h23), 1'b1);

        // Break prefix, then reset partway through the next frame.
        frame("rst_f0", 8'hF0, good_par(8'hF0), 1'b1);
        send_bits({1'b1, good_par(8'h1B), 8'h1B, 1'b0}, 5);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid", {valid, makeBreak, extended, frame_err, outCode}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bp = 0;
        ep = 0;
        repeat (3) @(negedge clk);
        frame("rst_1b", 8'h1B, good_par(8'h1B), 1'b1);

        frame("bad_stop", 8'h42, good_par(8'h42), 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                send_bits(11'h001, 1);
                model_frame(1'b1, 8'h00, 1'b0, 1'b0);
                repeat (4) @(negedge clk);
                compare("rnd_glitch");
            end else begin
                if (r < 5)      b = 8'hF0;
                else if (r < 8) b = 8'hE0;
                else            b = 8'($urandom_range(0, 255));
                par = good_par(b);
                if ($urandom_range(0, 7) == 0) par = ~par;
                stp = ($urandom_range(0, 7) != 0);
                frame("rnd", b, par, stp);
            end
        end

        check("hold_viol", hold_viol, 0);
        check("both_viol", both_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
